// File: rtl/light_pkg.sv
// Shared types for the automatic-lighting design: controller states and press-type encoding.
package light_pkg;

  typedef enum logic [2:0] {
    AUTO_OFF   = 3'd0,
    AUTO_ON    = 3'd1,
    AUTO_HOLD  = 3'd2,
    MANUAL_OFF = 3'd3,
    MANUAL_ON  = 3'd4
  } light_state_t;

  typedef enum logic [1:0] {
    PRESS_NONE  = 2'd0,
    PRESS_SHORT = 2'd1,
    PRESS_LONG  = 2'd2
  } press_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/light_timer.sv
// Clearable, enabled, saturating up-counter with a terminal-count compare against term.
module light_timer #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic         done
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en && (cnt_q != {W{1'b1}}))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign done = (cnt_q == term);

endmodule

// File: rtl/light_controller.sv
// Lamp controller: auto mode follows presence with hold-off, manual mode toggles on short press.
// Define LIGHT_CTRL_MANUAL_TIMEOUT_EN to turn the lamp off after MANUAL_MAX_T cycles in MANUAL_ON.
module light_controller
  import light_pkg::*;
#(
  parameter int AUTO_OFF_T   = 1000,
  parameter int MANUAL_MAX_T = 60000
) (
  input  logic clk,
  input  logic rst,
  input  logic press_short,
  input  logic press_long,
  input  logic presence,
  output logic lamp,
  output logic manual,
  output logic hold
);

`ifdef LIGHT_CTRL_MANUAL_TIMEOUT_EN
  localparam int CNT_MAX = max_int(AUTO_OFF_T, MANUAL_MAX_T);
  localparam bit MAN_TMO = 1'b1;
`else
  localparam int CNT_MAX = AUTO_OFF_T;
  localparam bit MAN_TMO = 1'b0;
`endif
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] AUTO_TERM = CNT_W'(AUTO_OFF_T - 1);
  // Without the timeout the counter never runs in MANUAL_ON, so this compare is inert there.
  localparam logic [CNT_W-1:0] MAN_TERM  = CNT_W'(MANUAL_MAX_T - 1);

  light_state_t state_q, state_d;
  logic         lamp_q, lamp_d;
  logic         manual_q, manual_d;
  logic         hold_q, hold_d;
  logic         cnt_en, cnt_clr, cnt_done;
  logic [CNT_W-1:0] cnt_term;
  press_t       press;

  assign press = press_long  ? PRESS_LONG  :
                 press_short ? PRESS_SHORT : PRESS_NONE;

  always_comb begin
    state_d = state_q;
    cnt_en  = 1'b0;
    case (state_q)
      AUTO_OFF: begin
        if (press == PRESS_LONG) state_d = MANUAL_OFF;
        else if (presence)       state_d = AUTO_ON;
      end
      AUTO_ON: begin
        if (press == PRESS_LONG) state_d = MANUAL_ON;
        else if (!presence)      state_d = AUTO_HOLD;
      end
      AUTO_HOLD: begin
        if (press == PRESS_LONG) state_d = MANUAL_ON;
        else if (presence)       state_d = AUTO_ON;
        else if (cnt_done)       state_d = AUTO_OFF;
        else                     cnt_en  = 1'b1;
      end
      MANUAL_OFF: begin
        if (press == PRESS_LONG)       state_d = presence ? AUTO_ON : AUTO_OFF;
        else if (press == PRESS_SHORT) state_d = MANUAL_ON;
      end
      MANUAL_ON: begin
        if (press == PRESS_LONG)       state_d = presence ? AUTO_ON : AUTO_OFF;
        else if (press == PRESS_SHORT) state_d = MANUAL_OFF;
        else if (MAN_TMO) begin
          if (cnt_done) state_d = MANUAL_OFF;
          else          cnt_en  = 1'b1;
        end
      end
      default: state_d = AUTO_OFF;
    endcase
  end

  // Counter runs only while staying in a timed state; any other cycle clears it.
  assign cnt_clr  = !cnt_en;
  assign cnt_term = (state_q == MANUAL_ON) ? MAN_TERM : AUTO_TERM;

  light_timer #(.W(CNT_W)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .term (cnt_term),
    .done (cnt_done)
  );

  always_comb begin
    lamp_d   = (state_d == AUTO_ON) || (state_d == AUTO_HOLD) || (state_d == MANUAL_ON);
    manual_d = (state_d == MANUAL_OFF) || (state_d == MANUAL_ON);
    hold_d   = (state_d == AUTO_HOLD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= AUTO_OFF;
      lamp_q   <= 1'b0;
      manual_q <= 1'b0;
      hold_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lamp_q   <= lamp_d;
      manual_q <= manual_d;
      hold_q   <= hold_d;
    end
  end

  assign lamp   = lamp_q;
  assign manual = manual_q;
  assign hold   = hold_q;

endmodule

// File: doc/light_controller.md
# light_controller

Lamp controller for the automatic-lighting design. Consumes the one-cycle short-press and long-press pulses from the push-button classifier and a presence-sensor level, and drives the lamp enable. It runs one of two modes. In automatic mode the lamp follows presence, with a hold-off delay. In manual mode short presses toggle the lamp directly.

## Interface
- `AUTO_OFF_T`, default 1000: cycles the lamp stays on in automatic mode after presence drops; legal range ≥ 1.
- `MANUAL_MAX_T`, default 60000: manual-mode lamp-on limit in cycles; used only when the configuration macro is defined; legal range ≥ 1.
- `clk`, input, 1: clock.
- `rst`, input, 1: reset, asynchronous, active-high.
- `press_short`, input, 1: one-cycle pulse for a short press; toggles the lamp in manual mode.
- `press_long`, input, 1: one-cycle pulse for a long press; toggles the mode.
- `presence`, input, 1: presence-sensor level, already synchronous to `clk`.
- `lamp`, output, 1: lamp enable, registered.
- `manual`, output, 1: high while in manual mode, registered.
- `hold`, output, 1: high while the automatic hold-off timer runs, registered.

## Operation
- States: AUTO_OFF, AUTO_ON, AUTO_HOLD, MANUAL_OFF, MANUAL_ON.
- Output decode:
  - `lamp` = 1 in AUTO_ON, AUTO_HOLD and MANUAL_ON.
  - `manual` = 1 in MANUAL_*.
  - `hold` = 1 in AUTO_HOLD.
- Reset: state AUTO_OFF, counter 0, all outputs 0.
- AUTO_OFF:
  - `presence` = 1 → AUTO_ON.
- AUTO_ON:
  - `presence` = 0 → AUTO_HOLD, counter cleared to 0.
- AUTO_HOLD:
  - `presence` = 1 → AUTO_ON, counter cleared.
  - Else, counter = `AUTO_OFF_T`-1 → AUTO_OFF.
  - Else counter increments.
- Long press in any AUTO_* state → MANUAL_ON if `lamp` is currently 1, else MANUAL_OFF. Lamp state is preserved and the counter is cleared.
- Long press in any MANUAL_* state → AUTO_ON if `presence` = 1, else AUTO_OFF. This applies regardless of the current lamp state.
- Short press:
  - MANUAL_OFF ↔ MANUAL_ON.
  - Ignored in AUTO_* states.
- `presence` is ignored in MANUAL_* states.
- Priority within one cycle: `press_long` > `press_short` > presence/timer. When both pulses arrive together, only the mode toggle takes effect.
- Counter width is `$clog2(max(AUTO_OFF_T, MANUAL_MAX_T)+1)`. The counter saturates and never wraps.
- Illegal state encoding → AUTO_OFF on the next edge.

## Timing
- All outputs are registered. An input sampled at edge N is reflected on the outputs after edge N.
- Lamp-on latency from `presence` rising in AUTO_OFF: 1 cycle.
- Lamp-off in automatic mode: `presence` falls and is sampled at edge N. AUTO_HOLD is entered at edge N. `lamp` falls at edge N+`AUTO_OFF_T`, provided `presence` stays 0 throughout.
- Presence returning at any hold cycle, including the last one (counter = `AUTO_OFF_T`-1), wins: → AUTO_ON, lamp stays on.
- Pulses are assumed exactly one cycle wide. A pulse held high for k cycles toggles k times; this is not filtered.
- `rst` asserted mid-operation: outputs go to 0 immediately (asynchronous). The first transition occurs at the first edge after deassertion.

## Configuration
- `LIGHT_CTRL_MANUAL_TIMEOUT_EN` defined:
  - MANUAL_ON clears the counter on entry and counts each cycle.
  - At counter = `MANUAL_MAX_T`-1 → MANUAL_OFF (the lamp turns off and the controller stays in manual mode).
  - A short or long press before that point takes normal priority.
- Not defined: MANUAL_ON persists indefinitely, `MANUAL_MAX_T` is unused, and the counter width is sized by `AUTO_OFF_T` alone.

## Structure
- Shared package `light_pkg`: state enum `light_state_t` (3-bit, the five states above). The same package is used by the classifier and the top level for press-type encoding.
- One sub-module, `light_timer`: clearable, enabled, saturating counter with a parameterised width and a `done` output for terminal count. It is instantiated once and shared by AUTO_HOLD and, when enabled, MANUAL_ON.
- The FSM, priority logic and output registers remain in `light_controller`.

## Test plan
Parameters for all scenarios: `AUTO_OFF_T`=8, `MANUAL_MAX_T`=20.
1. Reset, then `presence`=1 for 3 cycles, then 0 → `lamp` rises 1 cycle after `presence` and falls exactly 8 cycles after `presence` falls; `hold` is high for those 8 cycles.
2. In AUTO_HOLD, `presence` pulses high at hold cycle 7 → `lamp` stays 1, `hold` drops, state is AUTO_ON.
3. Lamp on in auto, then `press_long` → `manual`=1 and `lamp` stays 1. `press_short` → `lamp`=0. A second `press_short` → `lamp`=1.
4. In manual mode, `press_long` and `press_short` in the same cycle with `presence`=0 → `manual`=0, `lamp`=0; the short press has no effect.
5. With the macro defined, MANUAL_ON idle → `lamp` falls after 20 cycles and `manual` stays 1. Without the macro, `lamp` is still 1 after 100 cycles.
6. `rst` asserted mid-AUTO_HOLD → `lamp`, `hold` and `manual` are 0 immediately. After release with `presence`=0, the controller stays in AUTO_OFF.
